count_event_logger: RTL and testbench

- Consumer stage directly downstream of the 4-bit enable counter.
- Watches the counter's count output every clock and logs each value change into a small first-word-fall-through FIFO.
- Each logged record is the new count plus a wrap flag. Records drain through a valid/ready interface to the test harness or telemetry collector.
- Tracks FIFO overflow with a sticky flag and a saturating drop counter.

---
 rtl/count_event_logger.sv | 102 ++++++++++
 tb/tb_count_event_logger.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/count_event_logger.sv
// count_event_logger: logs each change of an upstream count into a first-word-fall-through FIFO, with overflow tracking
//
// Ports:
//   clk, rst              single rising-edge clock, asynchronous active-high reset
//   in_count, log_en      observed count and event-detection enable
//   out_valid/out_ready   valid/ready handshake for the head record
//   out_count, out_wrap   head record: new count value and all-ones-to-zero wrap flag
//   out_tstamp            head record cycle delta (zero unless COUNT_LOG_TSTAMP_EN)
//   level                 current FIFO occupancy
//   overflow, drop_cnt    sticky drop flag and saturating drop counter
//   overflow_clr          single-cycle clear of overflow and drop_cnt
// Optional feature macro: COUNT_LOG_TSTAMP_EN adds a per-record cycle delta.
module count_event_logger #(
  parameter int CW    = 4,
  parameter int DEPTH = 8,
  parameter int TSW   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CW-1:0]              in_count,
  input  logic                       log_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_count,
  output logic                       out_wrap,
  output logic [TSW-1:0]             out_tstamp,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       overflow_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
`ifdef COUNT_LOG_TSTAMP_EN
  localparam int W = CW + 1 + TSW;
`else
  localparam int W = CW + 1;
`endif
  logic [CW-1:0] prev_q;
  logic          prev_valid_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  rec, head;
  logic          ev, wrap, full, pop, push, drop;
  assign ev        = prev_valid_q && log_en && (in_count != prev_q);
  assign wrap      = (&prev_q) && (in_count == '0);
  assign full      = level_q == LW'(DEPTH);
  assign out_valid = level_q != '0;
  assign pop       = out_valid && out_ready;
  assign push      = ev && (!full || pop);
  assign drop      = ev && full && !pop;
  // Head is masked while empty so idle outputs read as zero after reset.
  assign head      = out_valid ? mem_q[rd_q] : '0;
  assign out_count = head[CW-1:0];
  assign out_wrap  = head[CW];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;
`ifdef COUNT_LOG_TSTAMP_EN
  logic [TSW-1:0] tcnt_q, tcnt_d;
  assign rec        = {tcnt_q, wrap, in_count};
  assign out_tstamp = head[CW+1 +: TSW];
  // Any detected event, pushed or dropped, restarts the delta at 1.
  assign tcnt_d     = ev ? TSW'(1) : tcnt_q + TSW'(tcnt_q != '1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
`else
  assign rec        = {wrap, in_count};
  assign out_tstamp = '0;
`endif
  always_comb begin
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = drop || (overflow_q && !overflow_clr);
    // A drop in the clear cycle leaves exactly one drop counted.
    drop_d     = overflow_clr ? 8'(drop) : drop_q + 8'(drop && drop_q != 8'hff);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      rd_q         <= '0;
      wr_q         <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      prev_q       <= in_count;
      prev_valid_q <= 1'b1;
      rd_q         <= rd_q + AW'(pop);
      wr_q         <= wr_q + AW'(push);
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= rec;
endmodule

// File: tb/tb_count_event_logger.sv
// tb_count_event_logger: randomized and directed stimulus against a queue-based scoreboard
module tb_count_event_logger;
  localparam int CW = 4, DEPTH = 8, TSW = 8, LW = $clog2(DEPTH+1);
  localparam int MAXC = (1 << CW) - 1, MAXT = (1 << TSW) - 1;
  logic clk = 0, rst = 1;
  logic [CW-1:0] in_count = '0;
  logic log_en = 0, out_ready = 0, overflow_clr = 0;
  logic out_valid, out_wrap, overflow;
  logic [CW-1:0] out_count;
  logic [TSW-1:0] out_tstamp;
  logic [LW-1:0] level;
  logic [7:0] drop_cnt;
  typedef struct { int cnt; int wrap; int ts; } rec_t;
  rec_t exp_q[$];
  int occ = 0, drops = 0, ovf = 0;
  int checks = 0, fails = 0;
  bit done = 0;
  always #5 clk = ~clk;
  count_event_logger #(.CW(CW), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .in_count(in_count), .log_en(log_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_wrap(out_wrap), .out_tstamp(out_tstamp), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .overflow_clr(overflow_clr)
  );
  initial begin : model
    int prev, tcnt;
    bit pv, ev, pop, push;
    rec_t r;
    prev = 0; tcnt = 0; pv = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        occ = 0; drops = 0; ovf = 0; pv = 0; prev = 0; tcnt = 0;
      end else begin
        ev = pv && log_en && int'(in_count) != prev;
        r.cnt = int'(in_count);
        r.wrap = (prev == MAXC && in_count == 0) ? 1 : 0;
        r.ts = 0;
`ifdef COUNT_LOG_TSTAMP_EN
        r.ts = tcnt;
        tcnt = ev ? 1 : (tcnt < MAXT ? tcnt + 1 : tcnt);
`endif
        pop = occ > 0 && out_ready;
        push = ev && (occ < DEPTH || pop);
        if (push) exp_q.push_back(r);
        occ = occ + int'(push) - int'(pop);
        if (overflow_clr) begin drops = 0; ovf = 0; end
        if (ev && !push) begin ovf = 1; if (drops < 255) drops++; end
        prev = int'(in_count);
        pv = 1;
      end
    end
  end
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask
  initial begin : monitor
    rec_t h;
    bit done_chk;
    done_chk = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_level", int'(level), 0);
        chk("async_drop_cnt", int'(drop_cnt), 0);
      end else begin
        chk("level", int'(level), occ);
        chk("valid", int'(out_valid), occ > 0 ? 1 : 0);
        chk("overflow", int'(overflow), ovf);
        chk("drop_cnt", int'(drop_cnt), drops);
        if (out_valid) begin
          if (exp_q.size() == 0) chk("unexpected_record", 1, 0);
          else begin
            h = exp_q[0];
            chk("out_count", int'(out_count), h.cnt);
            chk("out_wrap", int'(out_wrap), h.wrap);
            chk("out_tstamp", int'(out_tstamp), h.ts);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if (done && !done_chk) begin
          chk("drained", exp_q.size(), 0);
          done_chk = 1;
        end
      end
    end
  end
  task automatic step(input int c, input bit en, input bit rdy, input bit clr = 0);
    in_count = CW'(c); log_en = en; out_ready = rdy; overflow_clr = clr;
    @(posedge clk); #2;
  endtask
  task automatic pulse_rst();
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
  endtask
  initial begin : driver
    int cur;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    for (int i = 0; i <= 15; i++) step(i, 1, 1);
    step(0, 1, 1); step(1, 1, 1);
    repeat (3) step(1, 1, 1);
    for (int i = 0; i < 10; i++) step(2 + i, 1, 0);
    repeat (2) step(11, 1, 0);
    step(11, 1, 0, 1);
    step(11, 1, 0);
    for (int i = 0; i < 6; i++) step(i, 1, 0);
    step(12, 1, 1);
    step(12, 1, 0);
    repeat (10) step(12, 1, 1);
    for (int i = 0; i < 20; i++) step((13 + i) % 16, 1, i % 3 == 0);
    step(0, 1, 1, 1);
    repeat (10) step(0, 1, 1);
    in_count = 5;
    pulse_rst();
    repeat (3) step(5, 1, 1);
    repeat (2) step(9, 0, 1);
    repeat (3) step(10, 1, 1);
    step(11, 1, 0); step(12, 1, 0); step(13, 1, 0); step(14, 1, 0);
    pulse_rst();
    step(14, 1, 1); step(15, 1, 1);
    step(3, 1, 1);
    repeat (2) step(3, 1, 1);
    step(4, 1, 1);
    repeat (6) step(4, 1, 1);
    step(5, 1, 1);
    repeat (3) step(5, 1, 1);
    cur = 5;
    repeat (3000) begin
      if ($urandom_range(0, 3) != 0)
        cur = (cur == MAXC && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, MAXC));
      if ($urandom_range(0, 400) == 0) pulse_rst();
      step(cur, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    end
    repeat (DEPTH + 4) step(cur, 0, 1);
    done = 1;
    repeat (3) step(cur, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
